cim_temp_mem_arbiter: RTL
=========================

Name: cim_temp_mem_arbiter

Overview:
- Sits directly downstream of the CiM memory-access bundle (MemAccessSignals). Consumes the one-hot read/write request vectors, the per-source address table and the per-source write data from all 7 sources.
- Arbitrates these requests onto a single-port temporary-result SRAM (TEMP_RES_STORAGE_SIZE_CIM words x N_STORAGE bits).
- Returns read data, tagged with the requesting source, after a fixed latency.
- Keeps conflict and error telemetry for the CiM top-level.

Parameters:
- NUM_SRC, MEM_ACCESS_SRC_NUM (7): number of request sources; index equals MEM_ACCESS_SRC_T value.
- DEPTH, TEMP_RES_STORAGE_SIZE_CIM: SRAM depth in words.
- DATA_W, N_STORAGE: word width.
- ADDR_W, $clog2(DEPTH): address width.
- CNT_W, 16: conflict counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- read_req_src  input  NUM_SRC  one-hot read request, bit i = source i
- write_req_src  input  NUM_SRC  one-hot write request
- addr_table  input  NUM_SRC x ADDR_W  per-source address
- write_data  input  NUM_SRC x DATA_W  per-source write data
- rd_gnt  output  NUM_SRC  combinational read grant
- wr_gnt  output  NUM_SRC  combinational write grant
- rd_data  output  DATA_W  registered read data
- rd_valid  output  1  rd_data valid this cycle
- rd_src  output  NUM_SRC  one-hot source owning rd_data
- conflict_cnt  output  CNT_W  saturating count of cycles with >1 request bit set
- err_oob  output  1  sticky: granted address >= DEPTH
- err_rw_same_src  output  1  sticky: one source requested read and write in the same cycle
- clr_status  input  1  synchronous clear of conflict_cnt and both sticky errors

Behaviour:
- Reset values: rd_data=0, rd_valid=0, rd_src=0, conflict_cnt=0, err_oob=0, err_rw_same_src=0; pipeline valid bits cleared.
  - SRAM contents are NOT cleared.
  - Reset mid-operation drops in-flight reads: no rd_valid is emitted for them.
- Arbitration, combinational, one access per cycle:
  - Candidate set = read_req_src | write_req_src.
  - Winner = lowest index with a bit set (BUS_FSM highest priority, SOFTMAX lowest).
  - If the winner has its write bit set, wr_gnt[winner]=1 and the op is a write. Otherwise rd_gnt[winner]=1 and the op is a read.
  - At most one bit of rd_gnt|wr_gnt is high; all grants are 0 when no request is present.
  - Losers receive no grant and must hold their request; the arbiter keeps no memory of losers.
- Write: SRAM is written at the rising edge ending the grant cycle, with addr_table[winner] / write_data[winner].
- Read: SRAM samples the address at edge E0 (end of grant cycle); the output register captures at E1.
  - rd_valid=1 with rd_src=one-hot(winner) in the cycle following E1, i.e. 2 cycles after the grant cycle.
  - Back-to-back reads stream one per cycle.
- Read-after-write to the same address in consecutive grant cycles returns the new data (SRAM write-first is not needed, since accesses are serialised).
- Out-of-bounds: if the granted address >= DEPTH:
  - writes are suppressed;
  - reads still produce rd_valid with rd_data=0;
  - err_oob is set.
- Same source requesting both read and write: the write wins, the read is not granted, and err_rw_same_src is set.
- conflict_cnt increments when popcount(read_req_src|write_req_src) > 1, or when err_rw_same_src is raised in that cycle. It saturates at all-ones.
- clr_status has priority over a same-cycle increment or error set; the counter/flags read 0 next cycle.
- Pipeline state: two stages (S1: op valid + src; S2: output register).

Decomposition:
- Shared package (cim pkg): MEM_ACCESS_SRC_T, MEM_ACCESS_SRC_NUM, TEMP_RES_STORAGE_SIZE_CIM, N_STORAGE, TEMP_RES_ADDR_T.
- Shared package also gets a new typedef MEM_OP_T {MEM_OP_NONE, MEM_OP_READ, MEM_OP_WRITE}.
- One natural sub-module: cim_temp_sram_sp, a single-port synchronous SRAM wrapper (1-cycle read latency, write enable, DEPTH/DATA_W params) so a macro can be swapped in.
- Arbiter, pipeline and status logic stay in the top.

Test Plan:
- Reset then single write: write_req_src=1<<MAC, addr=5, data=0xAB for 1 cycle; then read_req_src=1<<MAC, addr=5 -> wr_gnt[MAC]=1 in the write cycle; rd_valid=1, rd_data=0xAB, rd_src=1<<MAC two cycles after the read grant.
- Contention: read from LAYERNORM (addr 3) and write from BUS_FSM (addr 7) in the same cycle, both held -> cycle 1 wr_gnt[BUS_FSM] only, cycle 2 rd_gnt[LAYERNORM]; conflict_cnt=1.
- Streaming: MAC reads addr 0..9 on consecutive cycles after preloading data=addr*3 -> 10 consecutive rd_valid cycles with rd_data 0,3,...,27 in order, no gaps.
- Same-source R+W: SOFTMAX asserts both, addr 2, data 0x11 -> wr_gnt[SOFTMAX]=1, rd_gnt=0, err_rw_same_src=1, conflict_cnt=1; clr_status -> all 0 next cycle.
- Out-of-bounds (DEPTH non-power-of-2, e.g. 848): write addr 900 then read addr 900 -> no SRAM write (prior contents intact), rd_data=0 with rd_valid, err_oob=1 sticky.
- Reset mid-read: grant a read, assert rst in the next cycle -> rd_valid never asserts for it; outputs at reset values; a subsequent read returns pre-reset SRAM data.

Source files
------------

// File: rtl/cim_temp_mem_arbiter_pkg.sv
// Shared CiM memory-access types: source indices, temp-result storage geometry
// and the memory operation encoding.
`default_nettype none

package cim_temp_mem_arbiter_pkg;

  localparam int MEM_ACCESS_SRC_NUM        = 7;
  localparam int TEMP_RES_STORAGE_SIZE_CIM = 848;
  localparam int N_STORAGE                 = 16;
  localparam int TEMP_RES_ADDR_W           = $clog2(TEMP_RES_STORAGE_SIZE_CIM);

  typedef logic [TEMP_RES_ADDR_W-1:0] TEMP_RES_ADDR_T;

  // Enum value is the request-vector bit index; lower index wins arbitration.
  typedef enum logic [2:0] {
    SRC_BUS_FSM   = 3'd0,
    SRC_LOGIC_FSM = 3'd1,
    SRC_MAC       = 3'd2,
    SRC_DENSE     = 3'd3,
    SRC_LAYERNORM = 3'd4,
    SRC_DATA_FILL = 3'd5,
    SRC_SOFTMAX   = 3'd6
  } MEM_ACCESS_SRC_T;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_READ  = 2'd1,
    MEM_OP_WRITE = 2'd2
  } MEM_OP_T;

endpackage

`default_nettype wire

// File: rtl/cim_temp_sram_sp.sv
// Single-port synchronous SRAM wrapper, one-cycle read latency.
// Kept as a thin shell so a foundry macro can replace the behavioural array.
`default_nettype none

module cim_temp_sram_sp #(
  parameter int DEPTH  = 848,
  parameter int DATA_W = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

`default_nettype wire

// File: rtl/cim_temp_mem_arbiter.sv
// Fixed-priority arbiter of the seven CiM memory-access sources onto the
// single-port temp-result SRAM, with tagged read return and status telemetry.
`default_nettype none

module cim_temp_mem_arbiter
  import cim_temp_mem_arbiter_pkg::*;
#(
  parameter int NUM_SRC = MEM_ACCESS_SRC_NUM,
  parameter int DEPTH   = TEMP_RES_STORAGE_SIZE_CIM,
  parameter int DATA_W  = N_STORAGE,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int CNT_W   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             read_req_src,
  input  logic [NUM_SRC-1:0]             write_req_src,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0] addr_table,
  input  logic [NUM_SRC-1:0][DATA_W-1:0] write_data,
  input  logic                           clr_status,
  output logic [NUM_SRC-1:0]             rd_gnt,
  output logic [NUM_SRC-1:0]             wr_gnt,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           rd_valid,
  output logic [NUM_SRC-1:0]             rd_src,
  output logic [CNT_W-1:0]               conflict_cnt,
  output logic                           err_oob,
  output logic                           err_rw_same_src
);

  localparam int              c_SRC_W = $clog2(NUM_SRC);
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [NUM_SRC-1:0] w_cand;
  logic [NUM_SRC-1:0] w_rd_gnt;
  logic [NUM_SRC-1:0] w_wr_gnt;
  logic [c_SRC_W-1:0] w_win;
  MEM_OP_T            w_op;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_oob;
  logic               w_multi;
  logic               w_rw_same;
  logic [DATA_W-1:0]  w_sram_q;

  always_comb begin
    w_cand   = read_req_src | write_req_src;
    w_win    = '0;
    w_rd_gnt = '0;
    w_wr_gnt = '0;
    w_op     = MEM_OP_NONE;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) w_win = c_SRC_W'(i);
    end
    // A source asking for both is treated as a write; its read is dropped.
    if (|w_cand) begin
      if (write_req_src[w_win]) begin
        w_wr_gnt[w_win] = 1'b1;
        w_op            = MEM_OP_WRITE;
      end else begin
        w_rd_gnt[w_win] = 1'b1;
        w_op            = MEM_OP_READ;
      end
    end
  end

  assign w_addr    = addr_table[w_win];
  assign w_wdata   = write_data[w_win];
  assign w_oob     = ({1'b0, w_addr} >= c_DEPTH);
  assign w_multi   = |(w_cand & (w_cand - 1'b1));
  assign w_rw_same = |(read_req_src & write_req_src);
  assign rd_gnt    = w_rd_gnt;
  assign wr_gnt    = w_wr_gnt;

  cim_temp_sram_sp #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clk     (clk),
    .i_we    ((w_op == MEM_OP_WRITE) && !w_oob && !rst),
    .i_re    ((w_op == MEM_OP_READ) && !w_oob && !rst),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_sram_q)
  );

  logic               r_s1_valid;
  logic               r_s1_oob;
  logic [NUM_SRC-1:0] r_s1_src;
  logic               r_rd_valid;
  logic [NUM_SRC-1:0] r_rd_src;
  logic [DATA_W-1:0]  r_rd_data;
  logic [CNT_W-1:0]   r_conflict_cnt;
  logic               r_err_oob;
  logic               r_err_rw_same;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_oob   <= 1'b0;
      r_s1_src   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_src   <= '0;
      r_rd_data  <= '0;
    end else begin
      r_s1_valid <= (w_op == MEM_OP_READ);
      r_s1_oob   <= w_oob;
      r_s1_src   <= w_rd_gnt;
      r_rd_valid <= r_s1_valid;
      r_rd_src   <= r_s1_valid ? r_s1_src : '0;
      if (r_s1_valid) r_rd_data <= r_s1_oob ? '0 : w_sram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_status) begin
      r_conflict_cnt <= '0;
      r_err_oob      <= 1'b0;
      r_err_rw_same  <= 1'b0;
    end else begin
      if ((w_multi || w_rw_same) && (r_conflict_cnt != '1))
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
      if ((w_op != MEM_OP_NONE) && w_oob) r_err_oob <= 1'b1;
      if (w_rw_same) r_err_rw_same <= 1'b1;
    end
  end

  assign rd_valid        = r_rd_valid;
  assign rd_src          = r_rd_src;
  assign rd_data         = r_rd_data;
  assign conflict_cnt    = r_conflict_cnt;
  assign err_oob         = r_err_oob;
  assign err_rw_same_src = r_err_rw_same;

endmodule

`default_nettype wire
